// File: rtl/alu_mdu_controller_pkg.sv
// Shared constants and types for the EX-stage ALU controller and its
// iterative multiply/divide unit.
package alu_mdu_controller_pkg;

   // ALU operation codes driven on Operation
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;

   // ALUOp classes produced by the main decoder
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RI     = 2'b10,
      ALUOP_JUMP   = 2'b11
   } aluop_t;

   // RV32M/RV64M funct3 codes
   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   // MDU sequencer states; the localparams are the encodings used in RTL
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mdu_controller_if.sv
// EX-stage bundle between the pipeline (master) and the ALU/MDU controller (slave).
// Handshake: ex_valid qualifies the instruction in EX; Stall is the back-pressure
// (the pipeline may advance only while Stall=0). An M-op is taken the first cycle
// it is seen with Stall=1 and retires on the single-cycle MduValid strobe, at
// which Stall=0 so the pipeline advances on that same edge. flush squashes the
// instruction and cancels any pending MduValid.
interface alu_mdu_controller_if #(parameter int XLEN = 32);
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            RType;
   logic            ex_valid;
   logic            flush;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic [3:0]      Operation;
   logic            MduSel;
   logic [XLEN-1:0] MduResult;
   logic            MduValid;
   logic            Stall;

   modport master (
      output ALUOp, Funct7, Funct3, RType, ex_valid, flush, SrcA, SrcB,
      input  Operation, MduSel, MduResult, MduValid, Stall
   );

   modport slave (
      input  ALUOp, Funct7, Funct3, RType, ex_valid, flush, SrcA, SrcB,
      output Operation, MduSel, MduResult, MduValid, Stall
   );
endinterface

// File: rtl/alu_mdu_controller_mdu_iterative.sv
// Iterative datapath: one shift-add multiply bit or one restoring-divide bit
// per step on unsigned magnitudes. Sign handling lives in the controller.
module alu_mdu_controller_mdu_iterative #(
   parameter int XLEN = 32,
   parameter int CW   = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            is_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [CW-1:0]   count_o,
   output logic [XLEN-1:0] nxt_hi_o,
   output logic [XLEN-1:0] nxt_lo_o
);
   // hi: product high half / partial remainder; lo: multiplier / quotient
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [CW-1:0]   cnt_q;
   logic            div_q;
   logic [XLEN:0]   sum, shifted, diff;

   // One iteration; exposed so the controller can fix up the final step's result
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted = {hi_q, lo_q[XLEN-1]};
      diff    = shifted - {1'b0, b_q};
      if (div_q) begin
         if (!diff[XLEN]) begin
            nxt_hi_o = diff[XLEN-1:0];
            nxt_lo_o = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            nxt_hi_o = shifted[XLEN-1:0];
            nxt_lo_o = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         nxt_hi_o = sum[XLEN:1];
         nxt_lo_o = {sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Operand load and per-step update of the working registers and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (load_i) begin
         hi_q  <= '0;
         lo_q  <= a_i;
         b_q   <= b_i;
         div_q <= is_div_i;
         cnt_q <= CW'(XLEN);
      end else if (step_i) begin
         hi_q  <= nxt_hi_o;
         lo_q  <= nxt_lo_o;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign count_o = cnt_q;
endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU controller: ALU operation decode plus sequencing of RV32M/RV64M
// operations on the iterative MDU, including stall, special cases and sign fix-up.
module alu_mdu_controller
   import alu_mdu_controller_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_mdu_controller_if.slave   bus,
   output mdu_state_t            dbg_state_o
);
   localparam int CW = $clog2(XLEN) + 1;

   logic [1:0]        state_q, state_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic              m_op, f7_base, f7_alt, r_ok;
   logic [3:0]        op;
   logic              sgn_a, sgn_b, a_neg, b_neg, is_div, neg_res;
   logic              div0, ovf, fast, short_path, load, step;
   logic [XLEN-1:0]   a_abs, b_abs, short_res, fix_res, q_s, r_s;
   logic [2*XLEN-1:0] full, prod, prod_s;
   logic [CW-1:0]     count;
   logic [XLEN-1:0]   nxt_hi, nxt_lo;

   // Decode ALUOp/Funct7/Funct3 into the ALU operation and detect M-ops
   always_comb begin
      m_op    = bus.ex_valid && (bus.ALUOp == ALUOP_RI) && bus.RType &&
                (bus.Funct7 == FUNCT7_MEXT);
      f7_base = (bus.Funct7 == FUNCT7_BASE);
      f7_alt  = (bus.Funct7 == FUNCT7_ALT);
      r_ok    = !bus.RType || f7_base;
      op      = OP_AND;
      case (bus.ALUOp)
         ALUOP_MEM, ALUOP_JUMP: op = OP_ADD;
         ALUOP_BRANCH:          op = OP_BEQ;
         default: begin
            if (m_op) op = OP_ADD;
            else begin
               case (bus.Funct3)
                  3'b000: begin
                     if (r_ok)        op = OP_ADD;
                     else if (f7_alt) op = OP_SUB;
                  end
                  3'b001: if (f7_base) op = OP_SLL;
                  3'b010: if (r_ok) op = OP_SLT;
                  3'b011: if (r_ok) op = OP_SLTU;
                  3'b100: if (r_ok) op = OP_XOR;
                  3'b101: begin
                     if (f7_base)     op = OP_SRL;
                     else if (f7_alt) op = OP_SRA;
                  end
                  3'b110: if (r_ok) op = OP_OR;
                  default: op = OP_AND;
               endcase
            end
         end
      endcase
   end

   // Operand magnitudes, result sign and the results that need no iteration
   always_comb begin
      is_div  = bus.Funct3[2];
      sgn_a   = (bus.Funct3 == M_MULH) || (bus.Funct3 == M_MULHSU) ||
                (bus.Funct3 == M_DIV)  || (bus.Funct3 == M_REM);
      sgn_b   = (bus.Funct3 == M_MULH) || (bus.Funct3 == M_DIV) ||
                (bus.Funct3 == M_REM);
      a_neg   = sgn_a && bus.SrcA[XLEN-1];
      b_neg   = sgn_b && bus.SrcB[XLEN-1];
      a_abs   = a_neg ? -bus.SrcA : bus.SrcA;
      b_abs   = b_neg ? -bus.SrcB : bus.SrcB;
      // remainder follows the dividend; quotient and product follow the sign xor
      neg_res = (is_div && bus.Funct3[1]) ? a_neg : (a_neg ^ b_neg);
      div0    = is_div && (bus.SrcB == '0);
      ovf     = is_div && !bus.Funct3[0] && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                (bus.SrcB == '1);
      fast    = FAST_MUL && !is_div;
      full    = '0;
      if (FAST_MUL) full = {{XLEN{a_neg}}, bus.SrcA} * {{XLEN{b_neg}}, bus.SrcB};
      if (div0)     short_res = bus.Funct3[1] ? bus.SrcA : '1;
      else if (ovf) short_res = bus.Funct3[1] ? '0 : bus.SrcA;
      else          short_res = (bus.Funct3 == M_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
      short_path = div0 || ovf || fast;
   end

   // Sign fix-up applied to the final iteration's values
   always_comb begin
      prod   = {nxt_hi, nxt_lo};
      prod_s = neg_q ? -prod : prod;
      q_s    = neg_q ? -nxt_lo : nxt_lo;
      r_s    = neg_q ? -nxt_hi : nxt_hi;
      case (f3_q)
         M_MUL:                     fix_res = prod_s[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:             fix_res = q_s;
         default:                   fix_res = r_s;
      endcase
   end

   // Sequencer next state: IDLE -> RUN -> DONE, or IDLE -> DONE on short paths
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_op && !bus.flush) begin
               if (short_path) begin
                  state_d = ST_DONE;
                  res_d   = short_res;
               end else begin
                  state_d = ST_RUN;
                  load    = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (bus.flush) state_d = ST_IDLE;
            else begin
               step = 1'b1;
               if (count == CW'(1)) begin
                  state_d = ST_DONE;
                  res_d   = fix_res;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, held result and the per-operation decode latched at launch
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         if (load) begin
            f3_q  <= bus.Funct3;
            neg_q <= neg_res;
         end
      end
   end

   alu_mdu_controller_mdu_iterative #(.XLEN(XLEN), .CW(CW)) u_mdu (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .step_i   (step),
      .is_div_i (is_div),
      .a_i      (a_abs),
      .b_i      (b_abs),
      .count_o  (count),
      .nxt_hi_o (nxt_hi),
      .nxt_lo_o (nxt_lo)
   );

   assign bus.Operation = op;
   assign bus.MduSel    = m_op;
   assign bus.MduResult = res_q;
   assign bus.MduValid  = (state_q == ST_DONE);
   assign bus.Stall     = (state_q == ST_RUN) ||
                          ((state_q == ST_IDLE) && m_op && !bus.flush);
   assign dbg_state_o   = mdu_state_t'(state_q);
endmodule
